bcd_to_binary_sm_seq: RTL
=========================

# bcd_to_binary_sm_seq

Sequential, parametrised successor to the calculator input unit's combinational BCD-to-sign-magnitude converter. Converts a DIGITS-nibble keypad/display BCD word, containing an optional minus-sign code, into a binary magnitude, sign flag and two's-complement value. It processes one nibble per clock under a start/valid handshake, so the ALU path carries no wide multiplier tree. It sits between the keypad entry register and the calculator ALU operand registers.

## Interface
- DIGITS, default 6: BCD nibbles in the input word (1..9).
- OUT_W, default 32: width of binary outputs; must satisfy 2^(OUT_W-1) > 10^DIGITS-1. Elaboration check fails otherwise.
- clk, input, 1: single clock; everything on rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request conversion; accepted only in IDLE.
- bcd, input, 4*DIGITS: BCD word, MSB nibble = most significant digit; sampled on accepted start.
- busy, output, 1: high while conversion is in progress (CONV state).
- valid, output, 1: one-cycle pulse when results update.
- binary_sm, output, OUT_W: magnitude.
- neg, output, 1: sign of result.
- binary_tc, output, OUT_W: two's-complement value (neg ? -binary_sm : binary_sm).
- err, output, 1: invalid nibble in magnitude field.

## Operation
- Codes: 0x0–0x9 digit; 0xE minus sign (calc_pkg BCD_MINUS); 0xA–0xD, 0xF invalid.
- FSM: IDLE -> CONV on start; CONV -> DONE after DIGITS nibbles; DONE -> IDLE unconditionally.
- Accept (IDLE, start=1): latch bcd into shift register; acc=0, seen_sign=0, bad=0, nib_cnt=DIGITS-1.
- Each CONV cycle consumes the current MSB nibble, then shifts left 4:
  - First 0xE (seen_sign=0): seen_sign=1, acc=0, bad=0. Everything left of the first minus is discarded, including invalid codes.
  - Digit d: acc = acc*10 + d. The multiply is computed as (acc<<3)+(acc<<1), OUT_W bits; it cannot overflow by the parameter rule.
  - Any other code, including a second 0xE: bad=1.
- DONE cycle: register the results and pulse valid.
  - bad=1: binary_sm=0, neg=0, err=1.
  - Otherwise: binary_sm=acc, neg=seen_sign && acc!=0, err=0. Negative zero is normalised to +0.
  - This covers a minus in the LSB nibble, giving 0 and neg=0.
- binary_tc is registered together with binary_sm/neg.
- Results hold stable from valid until the next valid.
- start outside IDLE is ignored (not queued).

## Timing
- Accept at edge N.
- busy=1 for cycles N+1 .. N+DIGITS.
- valid=1 and new outputs in cycle N+DIGITS+1.
- Latency start-to-valid: DIGITS+1 clocks (7 at default).
- Earliest next accept: cycle N+DIGITS+2, one idle cycle after DONE.
- Throughput: one conversion per DIGITS+2 clocks.
- reset=1: state IDLE; busy=0, valid=0, binary_sm=0, binary_tc=0, neg=0, err=0; internal acc/counters cleared.
- Reset during CONV aborts the conversion; no valid is produced and the outputs read 0.
- reset and start in the same cycle: reset wins, start is dropped.
- bcd may change freely after the accept edge.

## Structure
- calc_pkg holds:
  - BCD_MINUS = 4'hE, BCD_MAX_DIGIT = 4'h9.
  - FSM state enum (IDLE, CONV, DONE).
  - Function is_digit(nibble).
  - Shared with the binary-to-BCD display block.
- Sub-module bcd_mac10 (combinational, OUT_W param): acc_next = acc*10 + d via shift-add. It is reused by the display path's inverse logic.
- Top level contains: FSM, nibble shift register, $clog2(DIGITS) nibble counter, seen_sign/bad flags, output registers.

## Test plan
- bcd=0x123456, start -> valid exactly 7 cycles later; binary_sm=123456, neg=0, binary_tc=123456, err=0.
- bcd=0x3E0042 -> binary_sm=42, neg=1, binary_tc=0xFFFFFFD6, err=0. This checks that the leading digit left of the minus is ignored.
- bcd=0x00000E and bcd=0x0E0000 -> binary_sm=0, neg=0, err=0 (negative-zero normalisation).
- bcd=0xE12A45 -> err=1, binary_sm=0, neg=0. bcd=0xF1E009 -> binary_sm=9, neg=1, err=0, since the invalid code lies left of the minus.
- Handshake and reset:
  - start held high continuously -> accepts every 8 cycles; busy never overlaps valid.
  - Reset asserted at cycle 3 of CONV -> no valid; outputs 0; next start converts correctly.
- Parameter sweep DIGITS=1,4,9 (OUT_W=32), random legal words against a reference model -> bit-exact match and latency DIGITS+1.

Source files
------------

// File: rtl/calc_pkg.sv
// Purpose: shared calculator constants, FSM state type and BCD helpers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Shared by the BCD-to-binary converter and the binary-to-BCD display block.
package calc_pkg;

    // Keypad/display code for a minus sign inside a BCD word.
    localparam logic [3:0] BCD_MINUS     = 4'hE;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'h9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    function automatic logic is_digit(input logic [3:0] nibble);
        return (nibble <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Purpose: decimal multiply-accumulate step, acc_next = acc*10 + d.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: acc (running value), d (decimal digit 0..9), acc_next (result).
// The x10 is built as (acc<<3)+(acc<<1) so no multiplier is inferred.
module bcd_mac10 #(
    parameter int OUT_W = 32
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [3:0]       d,
    output logic [OUT_W-1:0] acc_next
);

    assign acc_next = (acc << 3) + (acc << 1) + OUT_W'(d);

endmodule

// File: rtl/bcd_to_binary_sm_seq.sv
// Purpose: serial BCD (with optional minus code) to sign-magnitude and two's-complement.
// Latency: DIGITS+1 clocks from accepted start to the valid pulse.
// Backpressure: start is honoured only in IDLE; requests while busy or in DONE are dropped.
// Ports: clk/reset (sync, active-high); start + bcd in; busy, valid, binary_sm, neg,
//        binary_tc, err out. All outputs are registered and hold until the next valid.
module bcd_to_binary_sm_seq
    import calc_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int OUT_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd,
    output logic                busy,
    output logic                valid,
    output logic [OUT_W-1:0]    binary_sm,
    output logic                neg,
    output logic [OUT_W-1:0]    binary_tc,
    output logic                err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

    // Largest magnitude must fit below the sign bit of the two's-complement output.
    generate
        if (DIGITS < 1 || DIGITS > 9 ||
            (OUT_W < 64 && (64'd1 << (OUT_W - 1)) <= MAX_VAL)) begin : g_param_check
            $error("bcd_to_binary_sm_seq: OUT_W too small for DIGITS, or DIGITS outside 1..9");
        end
    endgenerate

    conv_state_t        state;
    logic [BCD_W-1:0]   shreg;
    logic [CNT_W-1:0]   nib_cnt;
    logic [OUT_W-1:0]   acc;
    logic               seen_sign;
    logic               bad;

    logic [3:0]         cur_nib;
    logic [OUT_W-1:0]   mac_out;
    logic [OUT_W-1:0]   acc_nx;
    logic               seen_nx;
    logic               bad_nx;
    logic               neg_nx;

    assign cur_nib = shreg[BCD_W-1 -: 4];

    bcd_mac10 #(.OUT_W(OUT_W)) u_mac10 (
        .acc      (acc),
        .d        (cur_nib),
        .acc_next (mac_out)
    );

    // Per-nibble update. The first minus restarts the magnitude field, so any
    // digits or garbage to its left are forgotten.
    always_comb begin
        acc_nx  = acc;
        seen_nx = seen_sign;
        bad_nx  = bad;
        if (cur_nib == BCD_MINUS && !seen_sign) begin
            seen_nx = 1'b1;
            acc_nx  = '0;
            bad_nx  = 1'b0;
        end else if (is_digit(cur_nib)) begin
            acc_nx  = mac_out;
        end else begin
            bad_nx  = 1'b1;
        end
    end

    // -0 is reported as +0.
    assign neg_nx = seen_nx && (acc_nx != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            nib_cnt   <= '0;
            acc       <= '0;
            seen_sign <= 1'b0;
            bad       <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            binary_sm <= '0;
            binary_tc <= '0;
            neg       <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg     <= bcd;
                        acc       <= '0;
                        seen_sign <= 1'b0;
                        bad       <= 1'b0;
                        nib_cnt   <= CNT_W'(DIGITS - 1);
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    acc       <= acc_nx;
                    seen_sign <= seen_nx;
                    bad       <= bad_nx;
                    shreg     <= shreg << 4;
                    if (nib_cnt == '0) begin
                        // Results are registered on the last nibble so that
                        // valid is already high during the DONE cycle.
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= DONE;
                        if (bad_nx) begin
                            binary_sm <= '0;
                            binary_tc <= '0;
                            neg       <= 1'b0;
                            err       <= 1'b1;
                        end else begin
                            binary_sm <= acc_nx;
                            binary_tc <= neg_nx ? ('0 - acc_nx) : acc_nx;
                            neg       <= neg_nx;
                            err       <= 1'b0;
                        end
                    end else begin
                        nib_cnt <= nib_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
